// File: rtl/rv32i_ex_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_ex_pkg                                                     |
// | Shared types, opcodes and encoders for the RV32I EX sequencer.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package rv32i_ex_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic [31:0] iw;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] expected;
        logic [31:0] mask;
    } ex_vector_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Operand data is supplied directly, so all register fields encode x0.
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd0, 5'd0, f3, 5'd0, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm, 5'd0, f3, 5'd0, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd0, 5'd0, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] op);
        return {imm, 5'd0, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, OP_JAL};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_ex_vec_rom.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_ex_vec_rom                                                 |
// | Combinational vector table: index -> {iw,pc,rs1,rs2,exp,mask}.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rv32i_ex_vec_rom
    import rv32i_ex_pkg::*;
#(
    parameter  int NUM_VECTORS = 32,
    localparam int IDX_W       = $clog2(NUM_VECTORS)
) (
    input  logic [IDX_W-1:0] idx,
    output ex_vector_t       vec
);

    localparam logic [31:0] c_FULL = 32'hFFFF_FFFF;
    localparam logic [31:0] c_NUM  = 32'(NUM_VECTORS);

    logic [31:0] w_idx32;
    ex_vector_t  w_entry;

    assign w_idx32 = 32'(idx);

    function automatic ex_vector_t mk(input logic [31:0] iw, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] exp, input logic [31:0] mask);
        return {iw, pc, a, b, exp, mask};
    endfunction

    always_comb begin
        w_entry = '0;
        case (w_idx32)
            32'd0:  w_entry = mk(enc_r(7'h00, 3'd0), 32'h0, 32'h0200_0000, 32'h3000_0000, 32'h3200_0000, c_FULL);
            32'd1:  w_entry = mk(enc_r(7'h20, 3'd0), 32'h0, 32'd3,         32'd2,         32'd1,         c_FULL);
            32'd2:  w_entry = mk(enc_r(7'h00, 3'd1), 32'h0, 32'h0200_0000, 32'd2,         32'h0800_0000, c_FULL);
            32'd3:  w_entry = mk(enc_r(7'h00, 3'd2), 32'h0, 32'hFFFF_FFFF, 32'd1,         32'd1,         c_FULL);
            32'd4:  w_entry = mk(enc_r(7'h00, 3'd4), 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, c_FULL);
            32'd5:  w_entry = mk(enc_r(7'h00, 3'd5), 32'h0, 32'h8000_0000, 32'd4,         32'h0800_0000, c_FULL);
            32'd6:  w_entry = mk(enc_r(7'h20, 3'd5), 32'h0, 32'h8000_0000, 32'd4,         32'hF800_0000, c_FULL);
            32'd7:  w_entry = mk(enc_r(7'h00, 3'd6), 32'h0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, c_FULL);
            32'd8:  w_entry = mk(enc_r(7'h00, 3'd7), 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, c_FULL);
            32'd9:  w_entry = mk(enc_i(12'h123, 3'd0, OP_I), 32'h0, 32'h0000_1000, 32'h0, 32'h0000_1123, c_FULL);
            32'd10: w_entry = mk(enc_i(12'hFFF, 3'd2, OP_I), 32'h0, 32'hFFFF_FFF0, 32'h0, 32'd1,         c_FULL);
            32'd11: w_entry = mk(enc_i(12'hFFF, 3'd3, OP_I), 32'h0, 32'd5,         32'h0, 32'd1,         c_FULL);
            32'd12: w_entry = mk(enc_i(12'hFFF, 3'd4, OP_I), 32'h0, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000, c_FULL);
            32'd13: w_entry = mk(enc_i(12'h0AB, 3'd6, OP_I), 32'h0, 32'h1234_0000, 32'h0, 32'h1234_00AB, c_FULL);
            32'd14: w_entry = mk(enc_i(12'h0F0, 3'd7, OP_I), 32'h0, 32'h1234_5678, 32'h0, 32'h0000_0070, c_FULL);
            32'd15: w_entry = mk(enc_i(12'h004, 3'd1, OP_I), 32'h0, 32'h0000_0001, 32'h0, 32'h0000_0010, c_FULL);
            32'd16: w_entry = mk(enc_i(12'h008, 3'd5, OP_I), 32'h0, 32'h8000_0000, 32'h0, 32'h0080_0000, c_FULL);
            32'd17: w_entry = mk(enc_i(12'h408, 3'd5, OP_I), 32'h0, 32'h8000_0000, 32'h0, 32'hFF80_0000, c_FULL);
            32'd18: w_entry = mk(enc_i(12'hFF0, 3'd0, OP_I), 32'h0, 32'h0000_0010, 32'h0, 32'h0000_0000, c_FULL);
            32'd19: w_entry = mk(enc_i(12'h004, 3'd2, OP_LOAD), 32'h0, 32'h0000_2000, 32'h0, 32'h0000_2004, c_FULL);
            32'd20: w_entry = mk(enc_i(12'hFFF, 3'd0, OP_LOAD), 32'h0, 32'h0000_2000, 32'h0, 32'h0000_1FFF, c_FULL);
            32'd21: w_entry = mk(enc_s(12'h010, 3'd2), 32'h0, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_3010, c_FULL);
            // Byte store: only the word-aligned part of the address is checked.
            32'd22: w_entry = mk(enc_s(12'h7FF, 3'd0), 32'h0, 32'h0000_3001, 32'h0000_00A5, 32'h0000_3800, 32'hFFFF_FFFC);
            32'd23: w_entry = mk(enc_u(20'h12345, OP_LUI),   32'h0,         32'h0, 32'h0, 32'h1234_5000, c_FULL);
            32'd24: w_entry = mk(enc_u(20'hFFFFF, OP_LUI),   32'h0,         32'h0, 32'h0, 32'hFFFF_F000, c_FULL);
            32'd25: w_entry = mk(enc_u(20'h00001, OP_AUIPC), 32'h0000_0100, 32'h0, 32'h0, 32'h0000_1100, c_FULL);
            32'd26: w_entry = mk(enc_u(20'hFFFFF, OP_AUIPC), 32'h0000_1000, 32'h0, 32'h0, 32'h0000_0000, c_FULL);
            32'd27: w_entry = mk(enc_j(20'h00004),           32'h0000_0200, 32'h0, 32'h0, 32'h0000_0204, c_FULL);
            32'd28: w_entry = mk(enc_j(20'h00010),           32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0000, c_FULL);
            32'd29: w_entry = mk(enc_i(12'h000, 3'd0, OP_JALR), 32'h0000_0400, 32'h0000_1000, 32'h0, 32'h0000_0404, c_FULL);
            32'd30: w_entry = mk(enc_i(12'h010, 3'd0, OP_JALR), 32'h0000_0800, 32'h0000_2000, 32'h0, 32'h0000_0804, c_FULL);
            32'd31: w_entry = mk(enc_r(7'h00, 3'd3), 32'h0, 32'h0200_0000, 32'h2000_0000, 32'd1, c_FULL);
            default: w_entry = '0;
        endcase
    end

    // Out-of-range indices read as an all-zero vector whose zero mask always passes.
    assign vec = (w_idx32 < c_NUM) ? w_entry : '0;

endmodule
`default_nettype wire

// File: rtl/rv32i_ex_vec_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_ex_vec_seq                                                 |
// | Vector sequencer for the RV32I execute stage: issues table       |
// | vectors over valid/ready, checks masked results, keeps stats.    |
// | Optional first-failure capture: RV32I_EX_SEQ_FAILCAP_EN          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rv32i_ex_vec_seq
    import rv32i_ex_pkg::*;
#(
    parameter  int NUM_VECTORS    = 32,
    parameter  int XLEN           = 32,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int IDX_W          = $clog2(NUM_VECTORS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             single_step,
    input  logic [IDX_W-1:0] sel,
    output logic [XLEN-1:0]  iw_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic             issue_valid,
    input  logic             issue_ready,
    input  logic [XLEN-1:0]  result_in,
    input  logic             result_valid,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   pass_count,
    output logic [IDX_W:0]   fail_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             timeout
`ifdef RV32I_EX_SEQ_FAILCAP_EN
    ,
    output logic [XLEN-1:0]  first_fail_result,
    output logic [XLEN-1:0]  first_fail_expected
`endif
);

    localparam int               c_TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_VECTORS - 1);

    seq_state_t         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_step;
    logic               r_ff_seen;
    logic [c_TMR_W-1:0] r_timer;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    r_expected;
    logic [XLEN-1:0]    r_mask;

    logic             w_start_run;
    logic             w_expire;
    logic             w_pass;
    logic             w_advance;
    logic             w_fail;
    logic             w_last;
    logic             w_load;
    logic [IDX_W-1:0] w_rom_idx;
    ex_vector_t       w_vec;

    assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_expire    = (r_state == WAIT) && !result_valid && (r_timer == c_TMR_LAST);
    assign w_pass      = ((r_result ^ r_expected) & r_mask) == '0;
    assign w_advance   = (r_state == CHECK) || w_expire;
    assign w_fail      = ((r_state == CHECK) && !w_pass) || w_expire;
    assign w_last      = r_step || (r_idx == c_IDX_LAST);
    assign w_load      = w_start_run || (w_advance && !w_last);

    // The ROM is addressed with the index about to be loaded so operands
    // register on the same edge that raises issue_valid.
    assign w_rom_idx = w_start_run ? (single_step ? sel : '0) : (r_idx + 1'b1);

    rv32i_ex_vec_rom #(
        .NUM_VECTORS (NUM_VECTORS)
    ) u_rom (
        .idx (w_rom_idx),
        .vec (w_vec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_step         <= 1'b0;
            r_ff_seen      <= 1'b0;
            r_timer        <= '0;
            r_result       <= '0;
            r_expected     <= '0;
            r_mask         <= '0;
            iw_out         <= '0;
            pc_out         <= '0;
            rs1_data_out   <= '0;
            rs2_data_out   <= '0;
            issue_valid    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timeout        <= 1'b0;
        end else begin
            case (r_state)
                ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (result_valid) begin
                        r_result <= result_in;
                        r_state  <= CHECK;
                    end else if (!w_expire) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase

            if ((r_state == CHECK) && w_pass) begin
                pass_count <= pass_count + 1'b1;
            end
            if (w_fail) begin
                fail_count <= fail_count + 1'b1;
                if (!r_ff_seen) begin
                    first_fail_idx <= r_idx;
                    r_ff_seen      <= 1'b1;
                end
            end
            if (w_expire) begin
                timeout <= 1'b1;
            end

            if (w_advance && w_last) begin
                r_state <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
            end

            if (w_start_run) begin
                r_step         <= single_step;
                r_idx          <= w_rom_idx;
                r_ff_seen      <= 1'b0;
                pass_count     <= '0;
                fail_count     <= '0;
                first_fail_idx <= '0;
                timeout        <= 1'b0;
                done           <= 1'b0;
                busy           <= 1'b1;
            end else if (w_advance && !w_last) begin
                r_idx <= w_rom_idx;
            end

            if (w_load) begin
                iw_out       <= XLEN'(w_vec.iw);
                pc_out       <= XLEN'(w_vec.pc);
                rs1_data_out <= XLEN'(w_vec.rs1);
                rs2_data_out <= XLEN'(w_vec.rs2);
                r_expected   <= XLEN'(w_vec.expected);
                r_mask       <= XLEN'(w_vec.mask);
                issue_valid  <= 1'b1;
                r_state      <= ISSUE;
            end
        end
    end

`ifdef RV32I_EX_SEQ_FAILCAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_fail_result   <= '0;
            first_fail_expected <= '0;
        end else if (w_start_run) begin
            first_fail_result   <= '0;
            first_fail_expected <= '0;
        end else if (w_fail && !r_ff_seen) begin
            first_fail_result   <= w_expire ? '0 : r_result;
            first_fail_expected <= r_expected;
        end
    end
`endif

endmodule
`default_nettype wire
